// File: rtl/rv_iopmp_pkg.sv
// Shared types and constants for the sequential IOPMP decision logic.
// Holds the default configuration, FSM state encoding, table entry layouts and error codes.
package rv_iopmp_pkg;

  localparam int DL_SID_WIDTH        = 8;
  localparam int DL_NUMBER_MDS       = 2;
  localparam int DL_NUMBER_ENTRIES   = 32;
  localparam int DL_NUMBER_MASTERS   = 2;
  localparam int DL_NUMBER_INSTANCES = 8;

  typedef enum logic [1:0] {ACC_READ, ACC_WRITE, ACC_EXEC} access_t;

  typedef enum logic [1:0] {DL_IDLE, DL_SCAN, DL_RESP} dl_state_e;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_ILL_READ    = 3'd1;
  localparam logic [2:0] ERR_ILL_WRITE   = 3'd2;
  localparam logic [2:0] ERR_ILL_EXEC    = 3'd3;
  localparam logic [2:0] ERR_NO_HIT      = 3'd5;
  localparam logic [2:0] ERR_UNKNOWN_SID = 3'd6;

  typedef struct packed {
    logic [DL_NUMBER_MDS-1:0] md;
  } srcmd_entry_t;

  typedef struct packed {
    logic [15:0] t;
  } mdcfg_entry_t;

  function automatic logic [2:0] access_err(access_t acc);
    logic [2:0] code;
    case (acc)
      ACC_READ:  code = ERR_ILL_READ;
      ACC_WRITE: code = ERR_ILL_WRITE;
      ACC_EXEC:  code = ERR_ILL_EXEC;
      default:   code = ERR_ILL_READ;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rv_iopmp_dl_seq_if.sv
// Request/response handshake bundle between the transaction front-end and the decision logic.
// master drives requests and consumes decisions; slave is the decision logic itself.
interface rv_iopmp_dl_seq_if;

  logic                                   enable_i;
  logic                                   req_valid_i;
  logic                                   req_ready_o;
  logic [rv_iopmp_pkg::DL_SID_WIDTH-1:0]  sid_i;
  rv_iopmp_pkg::access_t                  access_type_i;
  logic                                   rsp_valid_o;
  logic                                   rsp_ready_i;
  logic                                   allow_transaction_o;
  logic                                   err_transaction_o;
  logic [2:0]                             err_type_o;
  logic [15:0]                            err_entry_index_o;

  modport master (
    output enable_i, req_valid_i, sid_i, access_type_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, allow_transaction_o, err_transaction_o,
           err_type_o, err_entry_index_o
  );

  modport slave (
    input  enable_i, req_valid_i, sid_i, access_type_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, allow_transaction_o, err_transaction_o,
           err_type_o, err_entry_index_o
  );

endinterface

// File: rtl/rv_iopmp_dl_md_mask.sv
// Marks which slots of the current window hold entries owned by the requesting SID's memory domains.
// MD m owns entries [mdcfg[m-1].t, mdcfg[m].t); with a single master every in-range entry is owned.
module rv_iopmp_dl_md_mask
  import rv_iopmp_pkg::*;
#(
  parameter int SID_WIDTH        = DL_SID_WIDTH,
  parameter int NUMBER_MDS       = DL_NUMBER_MDS,
  parameter int NUMBER_ENTRIES   = DL_NUMBER_ENTRIES,
  parameter int NUMBER_MASTERS   = DL_NUMBER_MASTERS,
  parameter int NUMBER_INSTANCES = DL_NUMBER_INSTANCES
) (
  input  logic [SID_WIDTH-1:0]        sid,
  input  logic [8:0]                  offset,
  input  srcmd_entry_t                srcmd_table [NUMBER_MASTERS],
  input  mdcfg_entry_t                mdcfg_table [NUMBER_MDS],
  output logic [NUMBER_INSTANCES-1:0] valid_mask
);

  logic [DL_NUMBER_MDS-1:0] md_bits;
  logic                     in_md;
  int                       lo;
  int                       idx;

  always_comb begin
    md_bits    = '0;
    in_md      = 1'b0;
    lo         = 0;
    idx        = 0;
    valid_mask = '0;
    for (int s = 0; s < NUMBER_MASTERS; s++) begin
      if (sid == SID_WIDTH'(s)) md_bits = srcmd_table[s].md;
    end
    for (int k = 0; k < NUMBER_INSTANCES; k++) begin
      in_md = 1'b0;
      lo    = 0;
      idx   = int'(offset) + k;
      for (int m = 0; m < NUMBER_MDS; m++) begin
        if (idx >= lo && idx < int'(mdcfg_table[m].t)) in_md = in_md | md_bits[m];
        lo = int'(mdcfg_table[m].t);
      end
      valid_mask[k] = (idx < NUMBER_ENTRIES) && ((NUMBER_MASTERS == 1) || in_md);
    end
  end

endmodule

// File: rtl/rv_iopmp_dl_seq.sv
// Multi-cycle IOPMP decision logic: scans the entry table one window per cycle and returns
// allow/deny with error info; priority entries decide immediately, the rest after the last window.
module rv_iopmp_dl_seq
  import rv_iopmp_pkg::*;
#(
  parameter int SID_WIDTH        = DL_SID_WIDTH,
  parameter int NUMBER_MDS       = DL_NUMBER_MDS,
  parameter int NUMBER_ENTRIES   = DL_NUMBER_ENTRIES,
  parameter int NUMBER_MASTERS   = DL_NUMBER_MASTERS,
  parameter int NUMBER_INSTANCES = DL_NUMBER_INSTANCES
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  rv_iopmp_dl_seq_if.slave            bus,
  input  logic [15:0]                 prio_entry_i,
  output logic [8:0]                  entry_offset_o,
  input  logic [NUMBER_INSTANCES-1:0] entry_match_i,
  input  logic [NUMBER_INSTANCES-1:0] entry_allow_i,
  input  srcmd_entry_t                srcmd_table_i [NUMBER_MASTERS],
  input  mdcfg_entry_t                mdcfg_table_i [NUMBER_MDS]
);

  localparam int NUM_WIN = (NUMBER_ENTRIES + NUMBER_INSTANCES - 1) / NUMBER_INSTANCES;
  localparam int CNT_W   = $clog2(NUM_WIN) + 1;

  dl_state_e            state_q, state_n;
  logic [CNT_W-1:0]     win_q, win_n;
  logic [SID_WIDTH-1:0] sid_q, sid_n;
  access_t              acc_q, acc_n;
  logic                 any_allow_q, any_allow_n;
  logic                 deny_found_q, deny_found_n;
  logic [15:0]          deny_idx_q, deny_idx_n;
  logic                 allow_q, allow_n;
  logic [2:0]           err_type_q, err_type_n;
  logic [15:0]          err_idx_q, err_idx_n;

  logic [NUMBER_INSTANCES-1:0] slot_valid;
  logic                        prio_hit, prio_allow, win_allow, win_deny;
  logic [15:0]                 prio_idx, win_deny_idx, slot_idx;
  logic                        acc_allow, acc_deny_found;
  logic [15:0]                 acc_deny_idx;

  assign entry_offset_o = (state_q == DL_SCAN) ? 9'(win_q) * 9'(NUMBER_INSTANCES) : 9'd0;

  rv_iopmp_dl_md_mask #(
    .SID_WIDTH        (SID_WIDTH),
    .NUMBER_MDS       (NUMBER_MDS),
    .NUMBER_ENTRIES   (NUMBER_ENTRIES),
    .NUMBER_MASTERS   (NUMBER_MASTERS),
    .NUMBER_INSTANCES (NUMBER_INSTANCES)
  ) u_md_mask (
    .sid         (sid_q),
    .offset      (entry_offset_o),
    .srcmd_table (srcmd_table_i),
    .mdcfg_table (mdcfg_table_i),
    .valid_mask  (slot_valid)
  );

  // Slots run in ascending index order, so priority slots of a straddling window come first.
  always_comb begin
    prio_hit     = 1'b0;
    prio_allow   = 1'b0;
    prio_idx     = '0;
    win_allow    = 1'b0;
    win_deny     = 1'b0;
    win_deny_idx = '0;
    slot_idx     = '0;
    for (int k = 0; k < NUMBER_INSTANCES; k++) begin
      slot_idx = 16'(entry_offset_o) + 16'(k);
      if (slot_valid[k] && entry_match_i[k]) begin
        if (slot_idx < prio_entry_i) begin
          if (!prio_hit) begin
            prio_hit   = 1'b1;
            prio_allow = entry_allow_i[k];
            prio_idx   = slot_idx;
          end
        end else if (entry_allow_i[k]) begin
          win_allow = 1'b1;
        end else if (!win_deny) begin
          win_deny     = 1'b1;
          win_deny_idx = slot_idx;
        end
      end
    end
    acc_allow      = any_allow_q | win_allow;
    acc_deny_found = deny_found_q | win_deny;
    acc_deny_idx   = deny_found_q ? deny_idx_q : win_deny_idx;
  end

  always_comb begin
    state_n      = state_q;
    win_n        = win_q;
    sid_n        = sid_q;
    acc_n        = acc_q;
    any_allow_n  = any_allow_q;
    deny_found_n = deny_found_q;
    deny_idx_n   = deny_idx_q;
    allow_n      = allow_q;
    err_type_n   = err_type_q;
    err_idx_n    = err_idx_q;
    case (state_q)
      DL_IDLE: begin
        if (bus.req_valid_i) begin
          sid_n        = bus.sid_i;
          acc_n        = bus.access_type_i;
          win_n        = '0;
          any_allow_n  = 1'b0;
          deny_found_n = 1'b0;
          deny_idx_n   = '0;
          if (!bus.enable_i) begin
            state_n    = DL_RESP;
            allow_n    = 1'b1;
            err_type_n = ERR_NONE;
            err_idx_n  = '0;
          end else if (NUMBER_MASTERS > 1 && int'(bus.sid_i) >= NUMBER_MASTERS) begin
            state_n    = DL_RESP;
            allow_n    = 1'b0;
            err_type_n = ERR_UNKNOWN_SID;
            err_idx_n  = '0;
          end else begin
            state_n = DL_SCAN;
          end
        end
      end
      DL_SCAN: begin
        if (prio_hit) begin
          state_n    = DL_RESP;
          allow_n    = prio_allow;
          err_type_n = prio_allow ? ERR_NONE : access_err(acc_q);
          err_idx_n  = prio_allow ? 16'd0 : prio_idx;
        end else if (win_q == CNT_W'(NUM_WIN - 1)) begin
          state_n    = DL_RESP;
          allow_n    = acc_allow;
          err_type_n = acc_allow ? ERR_NONE : (acc_deny_found ? access_err(acc_q) : ERR_NO_HIT);
          err_idx_n  = (acc_allow || !acc_deny_found) ? 16'd0 : acc_deny_idx;
        end else begin
          win_n        = win_q + 1'b1;
          any_allow_n  = acc_allow;
          deny_found_n = acc_deny_found;
          deny_idx_n   = acc_deny_idx;
        end
      end
      DL_RESP: begin
        if (bus.rsp_ready_i) state_n = DL_IDLE;
      end
      default: state_n = DL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= DL_IDLE;
      win_q        <= '0;
      sid_q        <= '0;
      acc_q        <= ACC_READ;
      any_allow_q  <= 1'b0;
      deny_found_q <= 1'b0;
      deny_idx_q   <= '0;
      allow_q      <= 1'b0;
      err_type_q   <= ERR_NONE;
      err_idx_q    <= '0;
    end else begin
      state_q      <= state_n;
      win_q        <= win_n;
      sid_q        <= sid_n;
      acc_q        <= acc_n;
      any_allow_q  <= any_allow_n;
      deny_found_q <= deny_found_n;
      deny_idx_q   <= deny_idx_n;
      allow_q      <= allow_n;
      err_type_q   <= err_type_n;
      err_idx_q    <= err_idx_n;
    end
  end

  assign bus.req_ready_o         = (state_q == DL_IDLE);
  assign bus.rsp_valid_o         = (state_q == DL_RESP);
  assign bus.allow_transaction_o = allow_q;
  assign bus.err_transaction_o   = (state_q == DL_RESP) & ~allow_q;
  assign bus.err_type_o          = err_type_q;
  assign bus.err_entry_index_o   = err_idx_q;

endmodule

// File: tb/tb_rv_iopmp_dl_seq.sv
// Randomized scoreboard bench for rv_iopmp_dl_seq: a flat per-entry reference model predicts
// each decision and its latency; a monitor checks every response cycle against the queue.
module tb_rv_iopmp_dl_seq;
  import rv_iopmp_pkg::*;

  localparam int NE   = DL_NUMBER_ENTRIES;
  localparam int NI   = DL_NUMBER_INSTANCES;
  localparam int NM   = DL_NUMBER_MASTERS;
  localparam int NMDS = DL_NUMBER_MDS;
  localparam int NWIN = (NE + NI - 1) / NI;

  typedef struct {
    bit         allow;
    bit [2:0]   etype;
    bit [15:0]  idx;
    int         lat;
    int         accept_cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_iopmp_dl_seq_if bus();
  logic [15:0]   prio_entry;
  logic [8:0]    entry_offset;
  logic [NI-1:0] entry_match, entry_allow;
  srcmd_entry_t  srcmd_table [NM];
  mdcfg_entry_t  mdcfg_table [NMDS];
  logic [NE-1:0] match_vec, allow_vec;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   cycle = 0;
  int   done_count = 0;
  int   hold_left = 0;
  bit   seen = 1'b0;

  rv_iopmp_dl_seq dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .prio_entry_i   (prio_entry),
    .entry_offset_o (entry_offset),
    .entry_match_i  (entry_match),
    .entry_allow_i  (entry_allow),
    .srcmd_table_i  (srcmd_table),
    .mdcfg_table_i  (mdcfg_table)
  );

  function automatic logic [NI-1:0] window_bits(logic [NE-1:0] v, logic [8:0] off);
    logic [NI-1:0] bits;
    int e;
    bits = '0;
    for (int k = 0; k < NI; k++) begin
      e = int'(off) + k;
      if (e < NE) bits[k] = v[e];
    end
    return bits;
  endfunction

  // Emulates the external matching logic, answering whatever window the DUT points at.
  always_comb begin
    entry_match = window_bits(match_vec, entry_offset);
    entry_allow = window_bits(allow_vec, entry_offset);
  end

  always @(posedge clk) cycle <= cycle + 1;

  function automatic exp_t ref_model(bit en, int sid, int acc, int prio,
                                     logic [NE-1:0] mv, logic [NE-1:0] av);
    exp_t r;
    bit owned, any_allow;
    int first_deny, lo;
    bit [2:0] code;
    r = '{allow: 1'b0, etype: 3'd0, idx: 16'd0, lat: 1, accept_cycle: 0};
    any_allow  = 1'b0;
    first_deny = -1;
    case (acc)
      1:       code = 3'd2;
      2:       code = 3'd3;
      default: code = 3'd1;
    endcase
    if (!en) begin
      r.allow = 1'b1;
      return r;
    end
    if (sid >= NM) begin
      r.etype = 3'd6;
      return r;
    end
    for (int j = 0; j < NE; j++) begin
      owned = 1'b0;
      lo    = 0;
      for (int m = 0; m < NMDS; m++) begin
        if (j >= lo && j < int'(mdcfg_table[m].t) && srcmd_table[sid].md[m]) owned = 1'b1;
        lo = int'(mdcfg_table[m].t);
      end
      if (owned && mv[j]) begin
        if (j < prio) begin
          r.lat = j / NI + 2;
          if (av[j]) r.allow = 1'b1;
          else begin
            r.etype = code;
            r.idx   = 16'(j);
          end
          return r;
        end
        if (av[j]) any_allow = 1'b1;
        else if (first_deny < 0) first_deny = j;
      end
    end
    r.lat = NWIN + 1;
    if (any_allow) r.allow = 1'b1;
    else if (first_deny >= 0) begin
      r.etype = code;
      r.idx   = 16'(first_deny);
    end else r.etype = 3'd5;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finishTest();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  endtask

  task automatic setTables(input int t0, input int t1, input int md0, input int md1);
    mdcfg_table[0].t = 16'(t0);
    mdcfg_table[1].t = 16'(t1);
    srcmd_table[0].md = NMDS'(md0);
    srcmd_table[1].md = NMDS'(md1);
  endtask

  task automatic applyStimulus(input bit en, input int sid, input int acc, input int prio,
                               input logic [NE-1:0] mv, input logic [NE-1:0] av,
                               input int hold, input bit expect_rsp);
    exp_t e;
    int n, target;
    n = 0;
    while (!bus.req_ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checkOutput("ready_timeout", 0, 1);
      finishTest();
    end
    match_vec         = mv;
    allow_vec         = av;
    prio_entry        = 16'(prio);
    hold_left         = hold;
    bus.enable_i      = en;
    bus.sid_i         = 8'(sid);
    bus.access_type_i = access_t'(acc);
    bus.req_valid_i   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    if (expect_rsp) begin
      e = ref_model(en, sid, acc, prio, mv, av);
      e.accept_cycle = cycle;
      exp_q.push_back(e);
      target = done_count + 1;
      n = 0;
      while (done_count < target && n < 100) begin
        @(posedge clk);
        n++;
      end
      #1;
      if (done_count < target) begin
        checkOutput("rsp_timeout", 0, 1);
        finishTest();
      end
    end
  endtask

  // Response acceptor: holds rsp_ready low for the requested number of valid cycles.
  initial begin
    bus.rsp_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.rsp_valid_o && hold_left > 0) begin
        bus.rsp_ready_i = 1'b0;
        hold_left--;
      end else begin
        bus.rsp_ready_i = 1'b1;
      end
    end
  end

  // Monitor: every cycle a response is shown it must equal the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q[0];
          if (!seen) begin
            seen = 1'b1;
            checkOutput("latency", cycle - e.accept_cycle + 1, e.lat);
          end
          checkOutput("allow", int'(bus.allow_transaction_o), int'(e.allow));
          checkOutput("err_transaction", int'(bus.err_transaction_o), int'(!e.allow));
          checkOutput("err_type", int'(bus.err_type_o), int'(e.etype));
          checkOutput("err_index", int'(bus.err_entry_index_o), int'(e.idx));
          if (bus.rsp_ready_i) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
            done_count++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    checkOutput("watchdog", 0, 1);
    finishTest();
  end

  initial begin
    logic [NE-1:0] mv, av;
    int t0;
    bus.req_valid_i   = 1'b0;
    bus.enable_i      = 1'b1;
    bus.sid_i         = '0;
    bus.access_type_i = ACC_READ;
    prio_entry        = '0;
    match_vec         = '0;
    allow_vec         = '0;
    setTables(16, 32, 1, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", int'(bus.req_ready_o), 1);
    checkOutput("reset_rsp_valid", int'(bus.rsp_valid_o), 0);
    checkOutput("reset_allow", int'(bus.allow_transaction_o), 0);
    checkOutput("reset_err_transaction", int'(bus.err_transaction_o), 0);
    checkOutput("reset_err_type", int'(bus.err_type_o), 0);
    checkOutput("reset_err_index", int'(bus.err_entry_index_o), 0);
    checkOutput("reset_offset", int'(entry_offset), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(1'b0, 1, 1, 8, 32'h0000_0008, 32'h0, 0, 1'b1);
    applyStimulus(1'b1, 5, 0, 8, 32'h0000_0008, 32'h0, 0, 1'b1);
    applyStimulus(1'b1, 0, 1, 8, 32'h0000_0008, 32'h0, 0, 1'b1);
    applyStimulus(1'b1, 1, 0, 0, 32'h0810_0000, 32'h0800_0000, 0, 1'b1);
    applyStimulus(1'b1, 0, 0, 8, 32'h0, 32'h0, 3, 1'b1);

    $display("[TB] reset during scan");
    applyStimulus(1'b1, 0, 0, 0, 32'h0, 32'h0, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("scan_window2_offset", int'(entry_offset), 2 * NI);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_rsp_valid", int'(bus.rsp_valid_o), 0);
    checkOutput("abort_req_ready", int'(bus.req_ready_o), 1);
    checkOutput("abort_offset", int'(entry_offset), 0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 0, 1, 8, 32'h0000_0008, 32'h0, 0, 1'b1);

    $display("[TB] randomized cases");
    for (int i = 0; i < 60; i++) begin
      t0 = int'($urandom_range(0, NE));
      setTables(t0, int'($urandom_range(t0, NE)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      mv = NE'($urandom & $urandom & $urandom);
      av = NE'($urandom);
      applyStimulus(($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, NE + 8)),
                    mv, av, int'($urandom_range(0, 2)), 1'b1);
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    finishTest();
  end

endmodule
